psram_access_scheduler: RTL and testbench
=========================================

Name: psram_access_scheduler

Overview:
- Sequences the triple-PSRAM QPI top block. Arbitrates single-word accesses between the acquisition write path and the host readback path.
- Drives quad_start, read_write and address; waits for endcommand; owns the write-address pointer and full flag; flags a hung driver.
- Sits between the acquisition FIFO / readback logic and the psram block. Runs on the same 84 MHz clock.

Parameters:
- ADDR_WIDTH, 23, PSRAM word address width.
- ADDR_STEP, 2, address increment per written word (16-bit word = 2 bytes).
- MAX_ADDR, 23'h7FFFFE, last writable address.
- TIMEOUT, 64, cycles allowed in WAIT before abort.
- STARVE_LIMIT, 4, consecutive write grants before a pending read must win.

Ports:
- clk_PSRAM  in  1  84 MHz PLL clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- qpi_on  in  1  psram initialization done.
- endcommand  in  1  one-cycle pulse, access finished.
- acq_enable  in  1  acquisition running; writes allowed.
- wr_pending  in  1  FIFO holds data (= !fifo_empty).
- rd_req  in  1  readback request, level; held until rd_done.
- rd_addr  in  ADDR_WIDTH  readback address, sampled at grant.
- quad_start  out  1  one-cycle start pulse to psram.
- read_write  out  2  0 none, 1 write, 2 read.
- address  out  ADDR_WIDTH  access address; stable ISSUE through WAIT.
- wr_grant  out  1  one-cycle pulse, FIFO word consumed by this write.
- rd_done  out  1  one-cycle pulse, data_out_1..3 valid.
- wr_addr  out  ADDR_WIDTH  next write address.
- mem_full  out  1  sticky, write pointer exhausted.
- timeout_err  out  1  sticky, endcommand missing.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_addr 0; starve counter 0. Reset mid-access aborts immediately and quad_start drops asynchronously.
- States:
  - IDLE: holds while !qpi_on. Otherwise picks a requester. Write eligible = acq_enable & wr_pending & !mem_full. Read eligible = rd_req.
  - Grant rule: write wins unless starve_cnt == STARVE_LIMIT and a read is eligible. A read grant clears starve_cnt; a write grant increments it, saturating at STARVE_LIMIT.
  - Grant latches read_write and address (wr_addr or rd_addr). Write grants pulse wr_grant in the same cycle. Next state ISSUE.
  - ISSUE: quad_start = 1 for exactly this cycle. Next state WAIT with timer cleared.
  - WAIT: timer increments each cycle.
    - On endcommand: read → pulse rd_done next cycle; write → wr_addr += ADDR_STEP, and if the old wr_addr == MAX_ADDR set mem_full instead (wr_addr holds). Next state DONE.
    - If timer == TIMEOUT-1 with no endcommand: set timeout_err and go to DONE; no address advance and no rd_done.
  - DONE: read_write = 0 for one cycle (recovery gap so mem_ce deasserts). Next state IDLE.
- Latency: grant to quad_start is 1 cycle. Minimum spacing between quad_start pulses is the driver time plus 3 cycles.
- endcommand outside WAIT is ignored. endcommand arriving in the same cycle as timer expiry counts as success.
- qpi_on falling while busy: the current access completes; no new grant.
- acq_enable falling mid-write: that write completes and the pointer advances.
- rd_req must stay high through rd_done; it is not re-sampled after grant.
- Burst mode is not issued; burst_mode is tied 0 by the integrator.

Optional Feature:
- PSRAM_SCHED_ROUND_ROBIN_EN defined: strict alternation whenever both requesters are eligible (last-granted loses); STARVE_LIMIT unused.
- Undefined: write priority with the starvation guard as above.

Decomposition:
- Package psram_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - RW_NONE=2'd0, RW_WRITE=2'd1, RW_READ=2'd2;
  - a default ADDR_STEP constant.
- One sub-module, psram_sched_arbiter: combinational grant plus the starve_cnt / last-grant register. The FSM, timer and pointers stay in the top.

Test Plan:
- qpi_on=0, wr_pending=1, acq_enable=1 for 50 cycles -> no quad_start, busy=0; raise qpi_on -> quad_start 2 cycles later, read_write=1, address=0, wr_grant pulse.
- 3 writes, endcommand 20 cycles after each start -> addresses 0, 2, 4 issued; wr_addr=6; busy high throughout each access.
- wr_pending and rd_req held continuously, rd_addr=0x100 -> grants W,W,W,W,R,W,W,W,W,R; with the macro defined -> W,R,W,R.
- wr_addr preloaded to MAX_ADDR via MAX_ADDR=4 build, 3 writes -> mem_full=1 after the third; further writes ignored and reads still served.
- endcommand suppressed -> timeout_err=1 after 64 WAIT cycles, wr_addr unchanged, return to IDLE; next access proceeds normally.
- rst_n low during WAIT -> all outputs 0 asynchronously; release -> idle, wr_addr=0, mem_full=0.

Source files
------------

// File: rtl/psram_access_scheduler_pkg.sv
// Shared types and constants for the PSRAM access scheduler.
// The FSM states, read_write encodings and the default word address step.
package psram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // One 16-bit word occupies two byte addresses.
  localparam int DEFAULT_ADDR_STEP = 2;

endpackage

// File: rtl/psram_access_scheduler_if.sv
// Scheduler-facing signal bundle: requesters, psram command channel and status.
// master = scheduler side, slave = surrounding logic (FIFO, readback, psram block).
interface psram_access_scheduler_if #(
  parameter int ADDR_WIDTH = 23
);

  logic                  qpi_on;
  logic                  endcommand;
  logic                  acq_enable;
  logic                  wr_pending;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  quad_start;
  logic [1:0]            read_write;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_grant;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  mem_full;
  logic                  timeout_err;
  logic                  busy;

  modport master (
    input  qpi_on, endcommand, acq_enable, wr_pending, rd_req, rd_addr,
    output quad_start, read_write, address, wr_grant, rd_done,
           wr_addr, mem_full, timeout_err, busy
  );

  modport slave (
    output qpi_on, endcommand, acq_enable, wr_pending, rd_req, rd_addr,
    input  quad_start, read_write, address, wr_grant, rd_done,
           wr_addr, mem_full, timeout_err, busy
  );

endinterface

// File: rtl/psram_access_scheduler_arbiter.sv
// Write/read grant selection plus its fairness state.
// PSRAM_SCHED_ROUND_ROBIN_EN selects strict alternation; otherwise write priority with a starvation guard.
module psram_sched_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_PSRAM,
  input  logic rst_n,
  input  logic wr_elig,
  input  logic rd_elig,
  input  logic take,
  output logic gnt_wr,
  output logic gnt_rd
);

`ifdef PSRAM_SCHED_ROUND_ROBIN_EN

  logic last_wr;

  // The requester granted last loses a tie; reset state lets the write go first.
  always_comb begin
    gnt_wr = wr_elig & (~rd_elig | ~last_wr);
    gnt_rd = rd_elig & ~gnt_wr;
  end

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (take && (gnt_wr || gnt_rd)) begin
      last_wr <= gnt_wr;
    end
  end

`else

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          rd_forced;

  always_comb begin
    rd_forced = rd_elig && (starve_cnt == LIMIT);
    gnt_wr    = wr_elig & ~rd_forced;
    gnt_rd    = rd_elig & ~gnt_wr;
  end

  // Counts consecutive write grants, saturating so a waiting read wins next.
  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (gnt_rd) begin
        starve_cnt <= '0;
      end else if (gnt_wr && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/psram_access_scheduler.sv
// Single-word access sequencer for the triple-PSRAM QPI block: arbitrates, issues, waits, recovers.
// Optional build macro PSRAM_SCHED_ROUND_ROBIN_EN switches the arbiter to strict alternation.
module psram_access_scheduler
  import psram_sched_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 23,
  parameter int                    ADDR_STEP    = DEFAULT_ADDR_STEP,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR     = 23'h7FFFFE,
  parameter int                    TIMEOUT      = 64,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                       clk_PSRAM,
  input  logic                       rst_n,
  psram_access_scheduler_if.master   bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  sched_state_e          state;
  logic [TW-1:0]         timer;
  logic [1:0]            rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  quad_start_q;
  logic                  wr_grant_q;
  logic                  rd_done_q;
  logic                  mem_full_q;
  logic                  timeout_q;
  logic                  busy_q;

  logic wr_elig;
  logic gnt_wr;
  logic gnt_rd;
  logic take;

  assign wr_elig = bus.acq_enable & bus.wr_pending & ~mem_full_q;
  assign take    = (state == IDLE) & bus.qpi_on;

  psram_sched_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk_PSRAM (clk_PSRAM),
    .rst_n     (rst_n),
    .wr_elig   (wr_elig),
    .rd_elig   (bus.rd_req),
    .take      (take),
    .gnt_wr    (gnt_wr),
    .gnt_rd    (gnt_rd)
  );

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      rw_q         <= RW_NONE;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      quad_start_q <= 1'b0;
      wr_grant_q   <= 1'b0;
      rd_done_q    <= 1'b0;
      mem_full_q   <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      quad_start_q <= 1'b0;
      wr_grant_q   <= 1'b0;
      rd_done_q    <= 1'b0;
      case (state)
        // Grant: latch command and address; a write consumes its FIFO word now.
        IDLE: begin
          if (take && (gnt_wr || gnt_rd)) begin
            state      <= ISSUE;
            busy_q     <= 1'b1;
            rw_q       <= gnt_wr ? RW_WRITE : RW_READ;
            addr_q     <= gnt_wr ? wr_addr_q : bus.rd_addr;
            wr_grant_q <= gnt_wr;
          end
        end
        ISSUE: begin
          quad_start_q <= 1'b1;
          timer        <= '0;
          state        <= WAIT;
        end
        // endcommand is checked before expiry so a pulse on the last cycle still succeeds.
        WAIT: begin
          if (bus.endcommand) begin
            if (rw_q == RW_READ) begin
              rd_done_q <= 1'b1;
            end else if (wr_addr_q == MAX_ADDR) begin
              mem_full_q <= 1'b1;
            end else begin
              wr_addr_q <= wr_addr_q + STEP;
            end
            rw_q  <= RW_NONE;
            state <= DONE;
          end else if (timer == TMAX) begin
            timeout_q <= 1'b1;
            rw_q      <= RW_NONE;
            state     <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // One idle-command cycle lets the psram chip enables drop before the next grant.
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          rw_q   <= RW_NONE;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.quad_start  = quad_start_q;
  assign bus.read_write  = rw_q;
  assign bus.address     = addr_q;
  assign bus.wr_grant    = wr_grant_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.mem_full    = mem_full_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_psram_access_scheduler.sv
// Bench for psram_access_scheduler: psram responder, transaction-level reference model, scenario tasks.
module tb_psram_access_scheduler;

  localparam int              AW     = 23;
  localparam logic [AW-1:0]   TB_MAX = 23'h20;
  localparam int              TMO    = 64;
  localparam int              SL     = 4;

  logic clk_PSRAM = 1'b0;
  logic rst_n     = 1'b0;

  always #6 clk_PSRAM = ~clk_PSRAM;

  psram_access_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  psram_access_scheduler #(
    .ADDR_WIDTH   (AW),
    .ADDR_STEP    (2),
    .MAX_ADDR     (TB_MAX),
    .TIMEOUT      (TMO),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk_PSRAM (clk_PSRAM),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_wr_addr;
  bit            m_full;
  bit            m_to;
  int            m_starve;
  bit            m_last_wr;

  function automatic logic [1:0] m_pick(input bit we, input bit re);
`ifdef PSRAM_SCHED_ROUND_ROBIN_EN
    if (we && re) return m_last_wr ? 2'd2 : 2'd1;
`else
    if (we && re) return (m_starve >= SL) ? 2'd2 : 2'd1;
`endif
    if (we) return 2'd1;
    if (re) return 2'd2;
    return 2'd0;
  endfunction

  task automatic m_grant(input logic [1:0] rw);
    if (rw == 2'd2) begin
      m_starve  = 0;
      m_last_wr = 0;
    end else begin
      m_starve  = (m_starve < SL) ? m_starve + 1 : SL;
      m_last_wr = 1;
    end
  endtask

  task automatic model_reset();
    m_wr_addr = '0;
    m_full    = 0;
    m_to      = 0;
    m_starve  = 0;
    m_last_wr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_PSRAM);
    rst_n           = 1'b0;
    bus.qpi_on      = 1'b0;
    bus.endcommand  = 1'b0;
    bus.acq_enable  = 1'b0;
    bus.wr_pending  = 1'b0;
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    model_reset();
    repeat (3) @(negedge clk_PSRAM);
    rst_n = 1'b1;
    @(negedge clk_PSRAM);
  endtask

  // Called at an IDLE-cycle negedge with requester inputs already set.
  task automatic run_access(input int lat, input bit respond, input bit drop_ctrl, input string nm,
                            output logic [1:0] got_rw, output logic [AW-1:0] got_addr);
    logic [1:0]    exp_rw;
    logic [AW-1:0] exp_addr;
    bit            we, prev_wg, stable_ok;
    int            waited;
    we       = bus.acq_enable && bus.wr_pending && !m_full;
    exp_rw   = m_pick(we, bus.rd_req);
    exp_addr = (exp_rw == 2'd2) ? bus.rd_addr : m_wr_addr;
    got_rw   = 2'd0;
    got_addr = '0;
    waited   = 0;
    prev_wg  = 0;
    while (!bus.quad_start && waited < 100) begin
      prev_wg = bus.wr_grant;
      @(negedge clk_PSRAM);
      waited++;
    end
    checks++;
    if (!bus.quad_start || waited != 2) begin
      errors++;
      $display("FAIL %s start_latency: quad_start=%b after %0d cycles, expected 1 after 2", nm, bus.quad_start, waited);
      return;
    end
    got_rw   = bus.read_write;
    got_addr = bus.address;
    checks++;
    if (bus.read_write !== exp_rw || bus.address !== exp_addr) begin
      errors++;
      $display("FAIL %s grant: read_write=%0d address=%h, expected read_write=%0d address=%h", nm, bus.read_write, bus.address, exp_rw, exp_addr);
    end
    checks++;
    if (prev_wg !== (exp_rw == 2'd1) || bus.wr_grant !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wr_grant: pulse_before_start=%b now=%b busy=%b, expected %b 0 1", nm, prev_wg, bus.wr_grant, bus.busy, exp_rw == 2'd1);
    end
    m_grant(exp_rw);
    if (drop_ctrl) begin
      bus.qpi_on     = 1'b0;
      bus.acq_enable = 1'b0;
    end
    stable_ok = 1;
    if (respond) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk_PSRAM);
        if (!bus.busy || bus.quad_start || bus.wr_grant || bus.rd_done ||
            bus.read_write !== exp_rw || bus.address !== got_addr) stable_ok = 0;
      end
      bus.endcommand = 1'b1;
      @(negedge clk_PSRAM);
      bus.endcommand = 1'b0;
      if (exp_rw == 2'd1) begin
        if (m_wr_addr == TB_MAX) m_full = 1;
        else m_wr_addr = m_wr_addr + 2;
      end
      checks++;
      if (!stable_ok) begin
        errors++;
        $display("FAIL %s wait_hold: busy/read_write/address not held during WAIT, expected held for %0d cycles", nm, lat);
      end
      checks++;
      if (bus.rd_done !== (exp_rw == 2'd2) || bus.read_write !== 2'd0 || bus.busy !== 1'b1 || bus.timeout_err !== m_to) begin
        errors++;
        $display("FAIL %s done_cycle: rd_done=%b read_write=%0d busy=%b timeout_err=%b, expected %b 0 1 %b", nm, bus.rd_done, bus.read_write, bus.busy, bus.timeout_err, exp_rw == 2'd2, m_to);
      end
      checks++;
      if (bus.wr_addr !== m_wr_addr || bus.mem_full !== m_full) begin
        errors++;
        $display("FAIL %s pointer: wr_addr=%h mem_full=%b, expected %h %b", nm, bus.wr_addr, bus.mem_full, m_wr_addr, m_full);
      end
    end else begin
      for (int i = 0; i < TMO - 1; i++) begin
        @(negedge clk_PSRAM);
        if (bus.timeout_err !== m_to || !bus.busy || bus.read_write !== exp_rw) stable_ok = 0;
      end
      @(negedge clk_PSRAM);
      m_to = 1;
      checks++;
      if (!stable_ok) begin
        errors++;
        $display("FAIL %s timeout_early: timeout flagged or access dropped before %0d WAIT cycles", nm, TMO);
      end
      checks++;
      if (bus.timeout_err !== 1'b1 || bus.read_write !== 2'd0 || bus.rd_done !== 1'b0 || bus.wr_addr !== m_wr_addr) begin
        errors++;
        $display("FAIL %s timeout: timeout_err=%b read_write=%0d rd_done=%b wr_addr=%h, expected 1 0 0 %h", nm, bus.timeout_err, bus.read_write, bus.rd_done, bus.wr_addr, m_wr_addr);
      end
    end
    @(negedge clk_PSRAM);
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_done !== 1'b0 || bus.timeout_err !== m_to) begin
      errors++;
      $display("FAIL %s idle: busy=%b rd_done=%b timeout_err=%b, expected 0 0 %b", nm, bus.busy, bus.rd_done, bus.timeout_err, m_to);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.quad_start, bus.read_write, bus.address, bus.wr_grant, bus.rd_done, bus.wr_addr,
         bus.mem_full, bus.timeout_err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: outputs qs=%b rw=%0d addr=%h wg=%b rd=%b wa=%h full=%b to=%b busy=%b, expected all 0",
               bus.quad_start, bus.read_write, bus.address, bus.wr_grant, bus.rd_done, bus.wr_addr, bus.mem_full, bus.timeout_err, bus.busy);
    end
  endtask

  task automatic test_qpi_gate();
    logic [1:0] rw;
    logic [AW-1:0] a;
    bit bad;
    do_reset();
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus.endcommand = (i == 20);
      @(negedge clk_PSRAM);
      if (bus.quad_start || bus.busy || bus.wr_grant) bad = 1;
    end
    bus.endcommand = 1'b0;
    checks++;
    if (bad || bus.wr_addr !== '0) begin
      errors++;
      $display("FAIL qpi_gate: activity=%b wr_addr=%h with qpi_on=0, expected no activity and 0", bad, bus.wr_addr);
    end
    bus.qpi_on = 1'b1;
    run_access(20, 1, 0, "first_write", rw, a);
    checks++;
    if (rw !== 2'd1 || a !== '0) begin
      errors++;
      $display("FAIL first_write_cmd: read_write=%0d address=%h, expected 1 000000", rw, a);
    end
  endtask

  task automatic test_writes();
    logic [1:0] rw;
    logic [AW-1:0] a;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_access(20, 1, 0, "writes", rw, a);
      checks++;
      if (a !== AW'(2 * i)) begin
        errors++;
        $display("FAIL writes_addr: write %0d address=%h, expected %h", i, a, AW'(2 * i));
      end
    end
    checks++;
    if (bus.wr_addr !== AW'(6)) begin
      errors++;
      $display("FAIL writes_ptr: wr_addr=%h, expected 000006", bus.wr_addr);
    end
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [1:0] rw;
    logic [AW-1:0] a;
    string seq, exp_seq;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = 23'h100;
    seq = "";
    for (int i = 0; i < 10; i++) begin
      run_access(int'($urandom_range(3, 15)), 1, 0, "arb", rw, a);
      seq = {seq, (rw == 2'd1) ? "W" : ((rw == 2'd2) ? "R" : "-")};
    end
`ifdef PSRAM_SCHED_ROUND_ROBIN_EN
    exp_seq = "WRWRWRWRWR";
`else
    exp_seq = "WWWWRWWWWR";
`endif
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL arb_sequence: got %s, expected %s", seq, exp_seq);
    end
    bus.rd_req     = 1'b0;
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_mem_full();
    logic [1:0] rw;
    logic [AW-1:0] a;
    bit bad;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    for (int i = 0; i < 17; i++) run_access(int'($urandom_range(1, 10)), 1, 0, "fill", rw, a);
    checks++;
    if (bus.mem_full !== 1'b1 || bus.wr_addr !== TB_MAX) begin
      errors++;
      $display("FAIL full_flag: mem_full=%b wr_addr=%h, expected 1 %h", bus.mem_full, bus.wr_addr, TB_MAX);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_PSRAM);
      if (bus.quad_start || bus.busy || bus.wr_grant) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_blocks_write: write issued while full=%b, expected none", bus.mem_full);
    end
    bus.rd_req  = 1'b1;
    bus.rd_addr = AW'($urandom());
    run_access(12, 1, 0, "read_when_full", rw, a);
    checks++;
    if (rw !== 2'd2) begin
      errors++;
      $display("FAIL read_when_full_cmd: read_write=%0d, expected 2", rw);
    end
    bus.rd_req     = 1'b0;
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] rw;
    logic [AW-1:0] a;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    run_access(0, 0, 0, "timeout", rw, a);
    checks++;
    if (bus.wr_addr !== '0 || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ptr: wr_addr=%h timeout_err=%b, expected 000000 1", bus.wr_addr, bus.timeout_err);
    end
    run_access(TMO - 1, 1, 0, "expiry_edge", rw, a);
    run_access(5, 1, 0, "after_timeout", rw, a);
    checks++;
    if (a !== AW'(2) || bus.wr_addr !== AW'(4)) begin
      errors++;
      $display("FAIL after_timeout_cmd: address=%h wr_addr=%h, expected 000002 000004", a, bus.wr_addr);
    end
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_qpi_drop();
    logic [1:0] rw;
    logic [AW-1:0] a;
    bit bad;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    run_access(10, 1, 1, "qpi_drop", rw, a);
    bus.acq_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_PSRAM);
      if (bus.quad_start || bus.busy) bad = 1;
    end
    checks++;
    if (bad || bus.wr_addr !== AW'(2)) begin
      errors++;
      $display("FAIL qpi_drop_idle: activity=%b wr_addr=%h, expected no activity and 000002", bad, bus.wr_addr);
    end
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rw;
    logic [AW-1:0] a;
    int n;
    do_reset();
    bus.qpi_on     = 1'b1;
    bus.acq_enable = 1'b1;
    bus.wr_pending = 1'b1;
    run_access(4, 1, 0, "pre_reset", rw, a);
    n = 0;
    while (!bus.quad_start && n < 10) begin
      @(negedge clk_PSRAM);
      n++;
    end
    checks++;
    if (!bus.quad_start) begin
      errors++;
      $display("FAIL reset_mid_start: quad_start=%b, expected 1", bus.quad_start);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.quad_start, bus.read_write, bus.address, bus.wr_grant, bus.rd_done, bus.wr_addr,
         bus.mem_full, bus.timeout_err, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: qs=%b rw=%0d addr=%h wa=%h busy=%b, expected all 0",
               bus.quad_start, bus.read_write, bus.address, bus.wr_addr, bus.busy);
    end
    bus.qpi_on = 1'b0;
    @(negedge clk_PSRAM);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_PSRAM);
    checks++;
    if (bus.busy || bus.quad_start || bus.wr_addr !== '0 || bus.mem_full) begin
      errors++;
      $display("FAIL reset_mid_release: busy=%b wr_addr=%h mem_full=%b, expected 0 000000 0", bus.busy, bus.wr_addr, bus.mem_full);
    end
    bus.qpi_on = 1'b1;
    run_access(6, 1, 0, "post_reset", rw, a);
    bus.wr_pending = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] rw;
    logic [AW-1:0] a;
    do_reset();
    bus.qpi_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.acq_enable = 1'($urandom_range(0, 1));
      bus.wr_pending = 1'($urandom_range(0, 1));
      bus.rd_req     = 1'($urandom_range(0, 1));
      bus.rd_addr    = AW'($urandom());
      if (!(bus.acq_enable && bus.wr_pending && !m_full) && !bus.rd_req) bus.rd_req = 1'b1;
      run_access(int'($urandom_range(1, 40)), ($urandom_range(0, 7) != 0), 0, "random", rw, a);
    end
    bus.rd_req     = 1'b0;
    bus.wr_pending = 1'b0;
  endtask

  initial begin
    bus.qpi_on     = 1'b0;
    bus.endcommand = 1'b0;
    bus.acq_enable = 1'b0;
    bus.wr_pending = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = '0;
    model_reset();
    test_reset();
    test_qpi_gate();
    test_writes();
    test_arbitration();
    test_mem_full();
    test_timeout();
    test_qpi_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at 5000000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
